// File: rtl/wdt_multi_if.sv
// Avalon-MM register slave bundle for the multi-channel watchdog.
// master drives address/strobes/data, slave returns registered readdata.
interface wdt_multi_if;
  logic [3:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/wdt_multi.sv
// wdt_multi: NUM_CH independent down-counting watchdogs behind Avalon-MM.
// Define WDT_MULTI_WINDOW_EN to build the early-kick window check.
module wdt_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int RST_LEN = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  wdt_multi_if.slave avs,
  input  logic       wdt_enable,
  output logic       irq,
  output logic       reset_out
);
  localparam logic [15:0] KEY = 16'h5A5A;

  typedef logic [CNT_W-1:0] cnt_t;

  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        unused_wdata;

  assign addr         = avs.avs_address;
  assign wdata        = avs.avs_writedata;
  assign unused_wdata = ^wdata;

  logic [NUM_CH-1:0] ctrl_q, ctrl_d;
  logic [NUM_CH-1:0] to_q, to_d;
  logic [NUM_CH-1:0] ek_q;
  cnt_t              cnt_q  [NUM_CH];
  cnt_t              cnt_d  [NUM_CH];
  cnt_t              load_q [NUM_CH];
  cnt_t              load_d [NUM_CH];
  logic [7:0]        pcnt_q, pcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       rmux;
  logic              irq_q, irq_d;

  logic              wr_ctrl, wr_stat, wr_kick;
  logic [NUM_CH-1:0] kick, rise, run, tmo, early;
  logic [NUM_CH-1:0] clr_to, clr_ek;

  // A programmed period of 0 is treated as 1.
  function automatic cnt_t reload(input cnt_t v);
    return (v == '0) ? cnt_t'(1) : v;
  endfunction

  assign wr_ctrl = avs.avs_write && (addr == 4'd0);
  assign wr_stat = avs.avs_write && (addr == 4'd1);
  assign wr_kick = avs.avs_write && (addr == 4'd2);

  assign kick = (wr_kick && wdata[31:16] == KEY)
              ? wdata[NUM_CH-1:0] : '0;
  assign rise = wr_ctrl
              ? (wdata[NUM_CH-1:0] & ~ctrl_q) : '0;
  assign run  = ctrl_q & {NUM_CH{wdt_enable}};

  assign ctrl_d = wr_ctrl ? wdata[NUM_CH-1:0] : ctrl_q;
  assign clr_to = wr_stat ? wdata[NUM_CH-1:0] : '0;
  assign clr_ek = wr_stat ? wdata[8 +: NUM_CH] : '0;

`ifdef WDT_MULTI_WINDOW_EN
  cnt_t              win_q, win_d;
  logic [NUM_CH-1:0] ek_d;

  assign win_d = (avs.avs_write && addr == 4'd3)
               ? wdata[CNT_W-1:0] : win_q;

  always_comb begin
    early = '0;
    for (int i = 0; i < NUM_CH; i++)
      early[i] = kick[i] && (cnt_q[i] > win_q);
  end

  assign ek_d = (ek_q & ~clr_ek) | early;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_q <= '0;
      ek_q  <= '0;
    end else begin
      win_q <= win_d;
      ek_q  <= ek_d;
    end
  end
`else
  logic unused_clr_ek;

  assign unused_clr_ek = ^clr_ek;
  assign early         = '0;
  assign ek_q          = '0;
`endif

  // Kick or enable-edge reloads take priority over the terminal count.
  always_comb begin
    tmo = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (rise[i] || kick[i]) begin
        cnt_d[i] = reload(load_q[i]);
      end else if (run[i]) begin
        if (cnt_q[i] <= cnt_t'(1)) begin
          tmo[i]   = 1'b1;
          cnt_d[i] = reload(load_q[i]);
        end else begin
          cnt_d[i] = cnt_q[i] - cnt_t'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      load_d[i] = load_q[i];
      if (avs.avs_write && addr == 4'(4 + i))
        load_d[i] = wdata[CNT_W-1:0];
    end
  end

  assign to_d  = (to_q & ~clr_to) | tmo;
  assign irq_d = |{to_q, ek_q};

  always_comb begin
    pcnt_d = pcnt_q;
    if (|{tmo, early})
      pcnt_d = 8'(RST_LEN);
    else if (pcnt_q != 8'd0)
      pcnt_d = pcnt_q - 8'd1;
  end

  always_comb begin
    rmux = '0;
    unique case (1'b1)
      (addr == 4'd0): rmux[NUM_CH-1:0] = ctrl_q;
      (addr == 4'd1): begin
        rmux[NUM_CH-1:0]  = to_q;
        rmux[8 +: NUM_CH] = ek_q;
      end
`ifdef WDT_MULTI_WINDOW_EN
      (addr == 4'd3): rmux[CNT_W-1:0] = win_q;
`endif
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (addr == 4'(4 + i))
            rmux[CNT_W-1:0] = load_q[i];
      end
    endcase
  end

  assign rdata_d = avs.avs_read ? rmux : rdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      to_q    <= '0;
      pcnt_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        load_q[i] <= '1;
      end
    end else begin
      ctrl_q  <= ctrl_d;
      to_q    <= to_d;
      pcnt_q  <= pcnt_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        load_q[i] <= load_d[i];
      end
    end
  end

  assign avs.avs_readdata = rdata_q;
  assign irq              = irq_q;
  assign reset_out        = (pcnt_q != 8'd0);
endmodule
